// File: rtl/lf_wave_gen.sv
// -----------------------------------------------------------------------------
// lf_wave_gen
//
// Programmable square-wave generator, 1..9999 Hz, 50 % duty. A four-digit BCD
// frequency is converted to binary and divided into a half-period cycle count.
// That count is then played out on o_so.
//
// Flow: IDLE -> CONV (4 cycles, BCD to binary)
//            -> DIV  (1 divisor setup cycle + DIV_W restoring steps)
//            -> RUN  (toggle o_so every `half` cycles)
//
// Parameters
//   CLK_HZ : system clock frequency in Hz (20_000 .. 2^32-1)
//   DIV_W  : divider / half-period counter width
//
// Ports
//   i_clk        : system clock, all logic on the rising edge
//   i_reset      : synchronous active-high reset, priority over i_load
//   i_load       : single-cycle request to program i_freq_bcd; it is honoured
//                  in IDLE and RUN and ignored while busy
//   i_freq_bcd   : four BCD digits, [15:12] thousands .. [3:0] units, in Hz
//   o_busy       : high while converting or dividing
//   o_err        : last accepted load was rejected (bad digit or zero)
//   o_so         : square-wave output
//   o_pulse_cnt  : saturating count of o_so rising edges. This port exists
//                  only when LF_GEN_PCNT_EN is defined.
//
// Optional feature macro: LF_GEN_PCNT_EN (pulse counter and o_pulse_cnt port).
// -----------------------------------------------------------------------------
module lf_wave_gen #(
   parameter longint unsigned CLK_HZ = 100_000_000,
   parameter int unsigned     DIV_W  = 32
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_load,
   input  logic [15:0] i_freq_bcd,
   output logic        o_busy,
   output logic        o_err,
   output logic        o_so
`ifdef LF_GEN_PCNT_EN
   ,output logic [15:0] o_pulse_cnt
`endif
);

   localparam logic [63:0]      CLK_VEC  = 64'(CLK_HZ);
   localparam logic [DIV_W-1:0] DIVIDEND = CLK_VEC[DIV_W-1:0];
   localparam int unsigned      CNT_W    = $clog2(DIV_W + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_CONV,
      S_DIV,
      S_RUN
   } state_t;

   // ---------------------------------------------------------------------------
   // Helper functions
   // ---------------------------------------------------------------------------

   // A load is valid when every digit is 0..9 and the value is not zero.
   function automatic logic bcd_valid(input logic [15:0] bcd);
      logic ok;
      ok = (bcd != 16'h0000);
      for (int i = 0; i < 4; i++) begin
         if (bcd[4*i +: 4] > 4'd9) ok = 1'b0;
      end
      return ok;
   endfunction

   // One Horner step of the BCD conversion: f*10 + digit.
   // The running value never exceeds 9999, so 14 bits are exact.
   function automatic logic [13:0] conv_step(input logic [13:0] f,
                                             input logic [3:0]  d);
      return (f * 14'd10) + {10'b0, d};
   endfunction

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   // ---------------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------------
   state_t           r_state;
   logic [15:0]      r_bcd;        // shifts up one digit per CONV cycle
   logic [1:0]       r_digit_cnt;
   logic [13:0]      r_freq;       // binary frequency, 1..9999
   logic [14:0]      r_dvsr;       // 2*f, at most 19998
   logic             r_dvsr_vld;   // first DIV cycle only latches the divisor
   logic [DIV_W-1:0] r_num;        // dividend, consumed MSB first
   logic [14:0]      r_rem;        // partial remainder, always < r_dvsr
   logic [DIV_W-1:0] r_quo;        // quotient = half-period in cycles
   logic [CNT_W-1:0] r_div_cnt;
   logic [DIV_W-1:0] r_cnt;        // half-period phase counter
   logic             r_busy;
   logic             r_err;
   logic             r_so;
`ifdef LF_GEN_PCNT_EN
   logic [15:0]      r_pulse_cnt;
`endif

   // ---------------------------------------------------------------------------
   // Combinational helpers
   // ---------------------------------------------------------------------------
   logic             w_accept;
   logic             w_bcd_ok;
   logic [15:0]      w_rem_sh;
   logic [15:0]      w_dvsr_ext;
   logic             w_q_bit;
   logic [14:0]      w_rem_diff;
   logic             w_div_last;
   logic             w_half_done;

   assign w_accept   = i_load && ((r_state == S_IDLE) || (r_state == S_RUN));
   assign w_bcd_ok   = bcd_valid(i_freq_bcd);

   // Restoring division step: bring down the next dividend bit, subtract the
   // divisor if it fits. The remainder stays below 2^15, so the shifted value
   // fits in 16 bits. The difference is only kept when the divisor fits, so a
   // 15-bit subtraction is exact.
   assign w_rem_sh   = {r_rem, r_num[DIV_W-1]};
   assign w_dvsr_ext = {1'b0, r_dvsr};
   assign w_q_bit    = (w_rem_sh >= w_dvsr_ext);
   assign w_rem_diff = w_rem_sh[14:0] - r_dvsr;
   assign w_div_last = (r_div_cnt == CNT_W'(DIV_W - 1));

   assign w_half_done = (r_cnt == (r_quo - DIV_W'(1)));

   // ---------------------------------------------------------------------------
   // Control FSM and datapath
   // ---------------------------------------------------------------------------
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state     <= S_IDLE;
         r_bcd       <= '0;
         r_digit_cnt <= '0;
         r_freq      <= '0;
         r_dvsr      <= '0;
         r_dvsr_vld  <= 1'b0;
         r_num       <= '0;
         r_rem       <= '0;
         r_quo       <= '0;
         r_div_cnt   <= '0;
         r_cnt       <= '0;
         r_busy      <= 1'b0;
         r_err       <= 1'b0;
         r_so        <= 1'b0;
`ifdef LF_GEN_PCNT_EN
         r_pulse_cnt <= '0;
`endif
      end else if (w_accept) begin
         // An accepted load always restarts from scratch. This happens whether
         // the load is valid or rejected, and in either case the old setting
         // is dropped.
         r_bcd       <= i_freq_bcd;
         r_digit_cnt <= '0;
         r_freq      <= '0;
         r_dvsr_vld  <= 1'b0;
         r_div_cnt   <= '0;
         r_cnt       <= '0;
         r_so        <= 1'b0;
`ifdef LF_GEN_PCNT_EN
         r_pulse_cnt <= '0;
`endif
         if (w_bcd_ok) begin
            r_state <= S_CONV;
            r_busy  <= 1'b1;
            r_err   <= 1'b0;
         end else begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_err   <= 1'b1;
         end
      end else begin
         unique case (r_state)
            S_IDLE: begin
               r_so <= 1'b0;
            end

            // BCD to binary, most significant digit first
            S_CONV: begin
               r_freq      <= conv_step(r_freq, r_bcd[15:12]);
               r_bcd       <= {r_bcd[11:0], 4'h0};
               r_digit_cnt <= r_digit_cnt + 2'd1;
               if (r_digit_cnt == 2'd3) begin
                  r_state    <= S_DIV;
                  r_num      <= DIVIDEND;
                  r_rem      <= '0;
                  r_quo      <= '0;
                  r_div_cnt  <= '0;
                  r_dvsr_vld <= 1'b0;
               end
            end

            // half = floor(CLK_HZ / (2*f)), one quotient bit per cycle
            S_DIV: begin
               if (!r_dvsr_vld) begin
                  r_dvsr     <= {r_freq, 1'b0};
                  r_dvsr_vld <= 1'b1;
               end else begin
                  r_num     <= {r_num[DIV_W-2:0], 1'b0};
                  r_rem     <= w_q_bit ? w_rem_diff : w_rem_sh[14:0];
                  r_quo     <= {r_quo[DIV_W-2:0], w_q_bit};
                  r_div_cnt <= r_div_cnt + CNT_W'(1);
                  if (w_div_last) begin
                     r_state <= S_RUN;
                     r_busy  <= 1'b0;
                     r_so    <= 1'b1;
                     r_cnt   <= '0;
`ifdef LF_GEN_PCNT_EN
                     r_pulse_cnt <= sat_inc16(r_pulse_cnt);
`endif
                  end
               end
            end

            // Playback: toggle after `half` cycles in each phase
            S_RUN: begin
               if (w_half_done) begin
                  r_cnt <= '0;
                  r_so  <= ~r_so;
`ifdef LF_GEN_PCNT_EN
                  if (!r_so) r_pulse_cnt <= sat_inc16(r_pulse_cnt);
`endif
               end else begin
                  r_cnt <= r_cnt + DIV_W'(1);
               end
            end

            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
               r_so    <= 1'b0;
            end
         endcase
      end
   end

   assign o_busy = r_busy;
   assign o_err  = r_err;
   assign o_so   = r_so;
`ifdef LF_GEN_PCNT_EN
   assign o_pulse_cnt = r_pulse_cnt;
`endif

endmodule

// File: tb/tb_lf_wave_gen.sv
// -----------------------------------------------------------------------------
// tb_lf_wave_gen
//
// Scoreboard bench for lf_wave_gen with CLK_HZ = 1 MHz. The stimulus pushes
// two kinds of expectation into queues. The first is output snapshots at
// given cycles (busy/err/so/pulse). The second is the expected first rise of
// o_so together with the half period. The bench model computes these from
// the decimal value of the BCD input.
//
// A separate monitor does two jobs. It times every o_so edge against the
// expected half period. It also checks the snapshots when their cycle comes
// up.
// -----------------------------------------------------------------------------
module tb_lf_wave_gen;

   localparam longint unsigned CLK_HZ = 1_000_000;
   localparam int LAT = 37;   // load edge to first so rise

   logic        clk = 1'b0;
   logic        rst;
   logic        ld;
   logic [15:0] bcd;
   logic        busy, err, so;
`ifdef LF_GEN_PCNT_EN
   logic [15:0] pulse;
`endif

   lf_wave_gen #(.CLK_HZ(CLK_HZ), .DIV_W(32)) dut (
      .i_clk      (clk),
      .i_reset    (rst),
      .i_load     (ld),
      .i_freq_bcd (bcd),
      .o_busy     (busy),
      .o_err      (err),
      .o_so       (so)
`ifdef LF_GEN_PCNT_EN
      ,.o_pulse_cnt(pulse)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {int ecyc; int busy; int err; int so; int pulse;} resp_t;
   typedef struct {int ecyc; int half;} rise_t;

   resp_t q_resp[$];
   rise_t q_rise[$];
   int    cyc    = 0;
   int    n_vec  = 0;
   int    n_fail = 0;

   // ------------------------------ reference model ---------------------------
   function automatic int bcd_to_int(logic [15:0] b);
      return int'(b[15:12]) * 1000 + int'(b[11:8]) * 100 +
             int'(b[7:4]) * 10 + int'(b[3:0]);
   endfunction

   function automatic bit bcd_ok(logic [15:0] b);
      if (b[15:12] > 9 || b[11:8] > 9 || b[7:4] > 9 || b[3:0] > 9) return 1'b0;
      return bcd_to_int(b) != 0;
   endfunction

   function automatic int model_half(logic [15:0] b);
      return int'(CLK_HZ / (2 * longint'(bcd_to_int(b))));
   endfunction

   function automatic logic [15:0] int_to_bcd(int f);
      logic [15:0] b;
      b[15:12] = 4'(f / 1000);
      b[11:8]  = 4'((f / 100) % 10);
      b[7:4]   = 4'((f / 10) % 10);
      b[3:0]   = 4'(f % 10);
      return b;
   endfunction

   task automatic check(string name, longint act, longint exp);
      n_vec++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ------------------------------ stimulus tasks ----------------------------
   task automatic do_load(logic [15:0] b);
      int e;
      @(negedge clk);
      e   = cyc + 1;
      bcd = b;
      ld  = 1'b1;
      if (bcd_ok(b)) begin
         q_resp.push_back('{e, 1, 0, 0, 0});
         q_resp.push_back('{e + LAT - 1, 1, 0, 0, 0});
         q_resp.push_back('{e + LAT, 0, 0, 1, 1});
         q_rise.push_back('{e + LAT, model_half(b)});
      end else begin
         q_resp.push_back('{e, 0, 1, 0, 0});
         q_resp.push_back('{e + 1, 0, 1, 0, 0});
      end
      @(negedge clk);
      ld = 1'b0;
   endtask

   // Load issued while the generator is computing; nothing may change.
   task automatic busy_load(logic [15:0] b);
      @(negedge clk);
      bcd = b;
      ld  = 1'b1;
      q_resp.push_back('{cyc + 1, 1, 0, 0, 0});
      q_resp.push_back('{cyc + 2, 1, 0, 0, 0});
      @(negedge clk);
      ld = 1'b0;
   endtask

   task automatic do_reset(int n);
      @(negedge clk);
      q_resp.delete();
      q_rise.delete();
      rst = 1'b1;
      ld  = 1'b0;
      for (int i = 1; i <= n; i++) q_resp.push_back('{cyc + i, 0, 0, 0, 0});
      repeat (n) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic wait_cyc(int n);
      repeat (n) @(negedge clk);
   endtask

   // ------------------------------ monitor -----------------------------------
   bit    tracking = 1'b0;
   int    cur_half = 0;
   int    last_e   = 0;
   logic  prev_so  = 1'b0;
   rise_t r_item;

   initial begin
      forever begin
         @(posedge clk);
         #1;
         cyc++;
         if (rst || busy) tracking = 1'b0;
         if (so && !prev_so) begin
            if (tracking) begin
               check("low_len", cyc - last_e, cur_half);
            end else if (q_rise.size() == 0) begin
               n_vec++;
               n_fail++;
               $display("FAIL unexpected_rise: so rose at cycle %0d, required no edge", cyc);
            end else begin
               r_item = q_rise.pop_front();
               check("rise_time", cyc, r_item.ecyc);
               cur_half = r_item.half;
               tracking = 1'b1;
            end
            last_e = cyc;
         end else if (!so && prev_so) begin
            if (err) tracking = 1'b0;
            if (tracking) check("high_len", cyc - last_e, cur_half);
            last_e = cyc;
         end
         prev_so = so;
         for (int i = q_resp.size() - 1; i >= 0; i--) begin
            if (q_resp[i].ecyc == cyc) begin
               check("rsp_busy", busy, q_resp[i].busy);
               check("rsp_err",  err,  q_resp[i].err);
               check("rsp_so",   so,   q_resp[i].so);
`ifdef LF_GEN_PCNT_EN
               check("rsp_pulse", pulse, q_resp[i].pulse);
`endif
               q_resp.delete(i);
            end
         end
      end
   end

   // ------------------------------ main sequence -----------------------------
   initial begin
      int e;
      int f;
      int h;
      logic [15:0] b;
      rst = 1'b1;
      ld  = 1'b0;
      bcd = 16'h0000;

      // reset, then 100 idle cycles
      do_reset(2);
      for (int i = 1; i <= 10; i++) q_resp.push_back('{cyc + 10 * i, 0, 0, 0, 0});
      wait_cyc(100);

      // rejected loads, then a valid start at 100 Hz
      do_load(16'h0A12);
      wait_cyc(5);
      do_load(16'h0000);
      wait_cyc(5);
      do_load(16'h0100);
      wait_cyc(LAT + 5000 + 100);

      // 250 Hz, three rising edges
      do_load(16'h0250);
      e = cyc;
      q_resp.push_back('{e + LAT + 8005, 0, 0, 1, 3});
      wait_cyc(LAT + 8000 + 100);

      // reload to 500 Hz at a random phase, extra load during DIV is ignored
      wait_cyc($urandom_range(0, 3999));
      do_load(16'h0500);
      wait_cyc(13);
      busy_load(16'h0250);
      wait_cyc(LAT + 4000 + 50);

      // reset during DIV
      do_load(16'h9999);
      wait_cyc(20);
      do_reset(1);
      wait_cyc(200);

      // 9999 Hz, then reset in the middle of a high phase
      do_load(16'h9999);
      wait_cyc(LAT + 200 + 10);
      do_reset(1);
      wait_cyc(300);

      // randomized loads
      for (int k = 0; k < 6; k++) begin
         if ($urandom_range(0, 3) == 0) begin
            b = int_to_bcd($urandom_range(0, 9999));
            f = $urandom_range(0, 3);
            b[4*f +: 4] = 4'($urandom_range(10, 15));
            do_load(b);
            wait_cyc($urandom_range(2, 20));
         end else begin
            f = $urandom_range(500, 9999);
            b = int_to_bcd(f);
            h = int'(CLK_HZ / (2 * longint'(f)));
            do_load(b);
            wait_cyc(LAT + 4 * h + $urandom_range(0, 2 * h));
         end
      end

      do_reset(2);
      wait_cyc(20);
      check("resp_queue_drained", q_resp.size(), 0);
      check("rise_queue_drained", q_rise.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
